// File: rtl/mult_exec_stage_pkg.sv
// mult_exec_stage_pkg: shared types for the multiply unit (func encoding, stage packet, CDB request, RS ready entry)
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif
package mult_exec_stage_pkg;
   localparam int XLEN = 32;
   localparam int ROB_TAG_LEN = `ROB_TAG_LEN;
   localparam int MUL_MAX_STAGES = 8;
   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3
   } mul_func_t;
   typedef struct packed {
      logic [ROB_TAG_LEN-1:0] rob_tag;
      logic [2:0]             func;
      logic [XLEN-1:0]        rs1_value;
      logic [XLEN-1:0]        rs2_value;
   } instr_ready_entry_t;
   typedef struct packed {
      logic                   valid;
      logic [ROB_TAG_LEN-1:0] rob_tag;
      logic [XLEN-1:0]        value;
   } cdb_data_t;
   typedef struct packed {
      logic                   valid;
      logic [ROB_TAG_LEN-1:0] rob_tag;
      logic [2:0]             func;
      logic [32:0]            mcand;
      logic [32:0]            mplier;
      logic [65:0]            acc;
   } mul_stage_packet_t;
   function automatic cdb_data_t mk_cdb(input logic v, input logic [ROB_TAG_LEN-1:0] tag, input logic [2:0] f, input logic [63:0] prod);
      mk_cdb.valid = v;
      mk_cdb.rob_tag = tag;
      mk_cdb.value = (f == MULH || f == MULHSU || f == MULHU) ? prod[63:32] : prod[31:0];
   endfunction
endpackage

// File: rtl/mult_exec_stage_if.sv
// mult_exec_stage_if: RS issue / CDB request bundle (issue_valid, issue_entry, cdb_grant in; exec_stall, cdb_req, busy out of the unit)
interface mult_exec_stage_if;
   import mult_exec_stage_pkg::*;
   logic               issue_valid;
   instr_ready_entry_t issue_entry;
   logic               cdb_grant;
   logic               exec_stall;
   cdb_data_t          cdb_req;
   logic               busy;
   modport master (output issue_valid, issue_entry, cdb_grant, input exec_stall, cdb_req, busy);
   modport slave (input issue_valid, issue_entry, cdb_grant, output exec_stall, cdb_req, busy);
endinterface

// File: rtl/mult_partial_stage.sv
// mult_partial_stage: combinational W-bit slice of the multiply; pkt_i in, pkt_o = pkt_i with acc += partial products of mplier bits [idx*W +: W]
module mult_partial_stage
   import mult_exec_stage_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [2:0]        idx,
   input  mul_stage_packet_t pkt_i,
   output mul_stage_packet_t pkt_o
);
   logic [65:0] mc;
   logic [65:0] term;
   logic [65:0] sum;
   logic [5:0]  j;
   always_comb begin
      mc = {{33{pkt_i.mcand[32]}}, pkt_i.mcand};
      sum = pkt_i.acc;
      term = '0;
      j = '0;
      for (int i = 0; i < W; i++) begin
         j = 6'(int'(idx) * W + i);
         term = pkt_i.mplier[j] ? (mc << j) : '0;
         // bit 31 of a sign-extended multiplier carries weight -2^31
         sum = (j == 6'd31 && pkt_i.mplier[32]) ? sum - term : sum + term;
      end
      pkt_o = pkt_i;
      pkt_o.acc = sum;
   end
endmodule

// File: rtl/mult_exec_stage.sv
// mult_exec_stage: pipelined MUL/MULH/MULHSU/MULHU unit (clk, reset, bus: RS issue in, exec_stall/cdb_req/busy out, cdb_grant in; MULT_PERF_CNT_EN adds perf_issued/perf_stall_cycles)
module mult_exec_stage
   import mult_exec_stage_pkg::*;
#(
   parameter int MUL_STAGES = 4
) (
   input logic clk,
   input logic reset,
   mult_exec_stage_if.slave bus
`ifdef MULT_PERF_CNT_EN
   ,
   output logic [31:0] perf_issued,
   output logic [31:0] perf_stall_cycles
`endif
);
   localparam int W = XLEN / MUL_STAGES;
   mul_stage_packet_t issue_pkt;
   mul_stage_packet_t stg_in [MUL_STAGES];
   mul_stage_packet_t stg_out [MUL_STAGES];
   mul_stage_packet_t pipe [MUL_STAGES];
   cdb_data_t cdb_q;
   logic advance;
   logic busy_c;
   assign advance = !cdb_q.valid | bus.cdb_grant;
   assign bus.exec_stall = bus.issue_valid & !advance;
   assign bus.cdb_req = cdb_q;
   assign bus.busy = busy_c;
   always_comb begin
      issue_pkt = '0;
      issue_pkt.valid = bus.issue_valid;
      issue_pkt.rob_tag = bus.issue_entry.rob_tag;
      issue_pkt.func = bus.issue_entry.func;
      issue_pkt.mcand = {(bus.issue_entry.func == MULH || bus.issue_entry.func == MULHSU) & bus.issue_entry.rs1_value[31], bus.issue_entry.rs1_value};
      issue_pkt.mplier = {(bus.issue_entry.func == MULH) & bus.issue_entry.rs2_value[31], bus.issue_entry.rs2_value};
   end
   // pipe[k] registers the output of slice k; the last slice feeds cdb_q directly
   for (genvar k = 0; k < MUL_STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign stg_in[k] = issue_pkt;
      end else begin : g_next
         assign stg_in[k] = pipe[k-1];
      end
      mult_partial_stage #(.W(W)) u_stage (.idx(3'(k)), .pkt_i(stg_in[k]), .pkt_o(stg_out[k]));
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cdb_q <= '0;
         for (int k = 0; k < MUL_STAGES; k++) pipe[k] <= '0;
      end else if (advance) begin
         cdb_q <= mk_cdb(stg_out[MUL_STAGES-1].valid, stg_out[MUL_STAGES-1].rob_tag, stg_out[MUL_STAGES-1].func, stg_out[MUL_STAGES-1].acc[63:0]);
         for (int k = 0; k < MUL_STAGES - 1; k++) pipe[k] <= stg_out[k];
      end
   end
   always_comb begin
      busy_c = cdb_q.valid;
      for (int k = 0; k < MUL_STAGES - 1; k++) busy_c = busy_c | pipe[k].valid;
   end
`ifdef MULT_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_issued <= '0;
         perf_stall_cycles <= '0;
      end else begin
         perf_issued <= perf_issued + 32'(bus.issue_valid & advance);
         perf_stall_cycles <= perf_stall_cycles + 32'(bus.exec_stall);
      end
   end
`endif
endmodule

// File: tb/tb_mult_exec_stage.sv
// tb_mult_exec_stage: directed table-driven bench for mult_exec_stage (MULT_PERF_CNT_EN enables counter checks)
module tb_mult_exec_stage;
   import mult_exec_stage_pkg::*;
   logic clk = 1'b0;
   logic reset;
   int checks = 0;
   int failures = 0;
   mult_exec_stage_if bus();
`ifdef MULT_PERF_CNT_EN
   logic [31:0] perf_issued;
   logic [31:0] perf_stall_cycles;
`endif
   mult_exec_stage #(.MUL_STAGES(4)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
`ifdef MULT_PERF_CNT_EN
      ,
      .perf_issued(perf_issued),
      .perf_stall_cycles(perf_stall_cycles)
`endif
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [2:0]  func;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [14];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic issue(input int tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      bus.issue_valid = 1'b1;
      bus.issue_entry = '{rob_tag: ROB_TAG_LEN'(tag), func: f, rs1_value: a, rs2_value: b};
   endtask
   task automatic wait_result(output cdb_data_t r);
      int n = 0;
      while (!bus.cdb_req.valid && n < 20) begin
         tick();
         n++;
      end
      r = bus.cdb_req;
   endtask
   initial begin
      cdb_data_t r;
      cdb_data_t held;
      int rx, nxt, exp_tag, denied, accepts;
      logic g;
      tbl[0]  = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000};
      tbl[1]  = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      tbl[2]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
      tbl[3]  = '{MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
      tbl[4]  = '{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
      tbl[5]  = '{MULH,   32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
      tbl[6]  = '{MULH,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
      tbl[7]  = '{MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000};
      tbl[8]  = '{MULHSU, 32'h00000002, 32'h80000000, 32'h00000001};
      tbl[9]  = '{MULHU,  32'h80000000, 32'h00000002, 32'h00000001};
      tbl[10] = '{MUL,    32'h12345678, 32'h00000010, 32'h23456780};
      tbl[11] = '{3'd5,   32'h00000003, 32'h00000004, 32'h0000000C};
      tbl[12] = '{MUL,    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE};
      tbl[13] = '{MULH,   32'h00000002, 32'h80000000, 32'hFFFFFFFF};
      reset = 1'b1;
      bus.issue_valid = 1'b0;
      bus.issue_entry = '0;
      bus.cdb_grant = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_req", 64'(bus.cdb_req), 64'd0);
      chk("reset_stall", 64'(bus.exec_stall), 64'd0);
      issue(5, MUL, 32'd7, 32'd6);
      tick();
      bus.issue_valid = 1'b0;
      chk("lat_busy", 64'(bus.busy), 64'd1);
      for (int i = 1; i <= 3; i++) begin
         chk("lat_early", 64'(bus.cdb_req.valid), 64'd0);
         tick();
      end
      chk("lat_req", 64'(bus.cdb_req), {25'd0, 1'b1, 6'd5, 32'd42});
      tick();
      chk("lat_drain_busy", 64'(bus.busy), 64'd0);
      for (int i = 0; i < 14; i++) begin
         issue(i + 1, tbl[i].func, tbl[i].a, tbl[i].b);
         tick();
         bus.issue_valid = 1'b0;
         wait_result(r);
         chk("vec_valid", 64'(r.valid), 64'd1);
         chk("vec_tag", 64'(r.rob_tag), 64'(i + 1));
         chk($sformatf("vec_value[%0d]", i), 64'(r.value), 64'(tbl[i].exp));
         tick();
      end
      rx = 0;
      for (int c = 0; c < 14 + 8; c++) begin
         if (c < 14) issue(c + 1, tbl[c].func, tbl[c].a, tbl[c].b);
         else bus.issue_valid = 1'b0;
         #1;
         if (c < 14) chk("stream_stall", 64'(bus.exec_stall), 64'd0);
         tick();
         if (bus.cdb_req.valid) begin
            if (rx < 14) begin
               chk("stream_cycle", 64'(c), 64'(rx + 3));
               chk("stream_tag", 64'(bus.cdb_req.rob_tag), 64'(rx + 1));
               chk($sformatf("stream_value[%0d]", rx), 64'(bus.cdb_req.value), 64'(tbl[rx].exp));
            end else chk("stream_extra", 64'(bus.cdb_req.valid), 64'd0);
            rx++;
         end
      end
      chk("stream_count", 64'(rx), 64'd14);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      nxt = 1;
      exp_tag = 1;
      denied = 0;
      accepts = 0;
      held = '0;
      for (int c = 0; c < 40 && exp_tag <= 8; c++) begin
         g = !(bus.cdb_req.valid && bus.cdb_req.rob_tag == ROB_TAG_LEN'(2) && denied < 3);
         bus.cdb_grant = g;
         if (nxt <= 8) issue(nxt, MUL, 32'(nxt), 32'd10);
         else bus.issue_valid = 1'b0;
         #1;
         if (!g) begin
            denied++;
            chk("bp_stall", 64'(bus.exec_stall), 64'd1);
            if (denied == 1) held = bus.cdb_req;
            else chk("bp_hold", 64'(bus.cdb_req), 64'(held));
         end else if (bus.issue_valid) chk("bp_nostall", 64'(bus.exec_stall), 64'd0);
         if (bus.cdb_req.valid && g) begin
            chk("bp_tag", 64'(bus.cdb_req.rob_tag), 64'(exp_tag));
            chk("bp_value", 64'(bus.cdb_req.value), 64'(exp_tag * 10));
            exp_tag++;
         end
         if (bus.issue_valid && !bus.exec_stall) begin
            nxt++;
            accepts++;
         end
         tick();
      end
      bus.cdb_grant = 1'b1;
      bus.issue_valid = 1'b0;
      chk("bp_all_tags", 64'(exp_tag), 64'd9);
      chk("bp_denied", 64'(denied), 64'd3);
      tick();
      chk("bp_no_dup", 64'(bus.cdb_req.valid), 64'd0);
      chk("bp_idle", 64'(bus.busy), 64'd0);
`ifdef MULT_PERF_CNT_EN
      chk("perf_stall_cycles", 64'(perf_stall_cycles), 64'd3);
      chk("perf_issued", 64'(perf_issued), 64'(accepts));
`endif
      for (int t = 10; t < 13; t++) begin
         issue(t, MUL, 32'(t), 32'd3);
         tick();
      end
      bus.issue_valid = 1'b0;
      chk("flush_busy_before", 64'(bus.busy), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("flush_busy", 64'(bus.busy), 64'd0);
      chk("flush_valid", 64'(bus.cdb_req.valid), 64'd0);
      issue(13, MUL, 32'd9, 32'd9);
      tick();
      bus.issue_valid = 1'b0;
      wait_result(r);
      chk("post_flush_req", 64'(r), {25'd0, 1'b1, 6'd13, 32'd81});
      tick();
      chk("post_flush_idle", 64'(bus.cdb_req.valid), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
